// File: rtl/ide_common_pkg.sv
// Shared constants and width helper for the input-conditioning blocks.
package ide_common_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_LEN     = 4;
  localparam int DEF_STRETCH     = 4;

  // Smallest width w (at least 1) such that 2**w >= n.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioning channel: synchroniser, counter debounce, edge pulses and
// a retriggerable stretcher, all in the clk domain.
module input_conditioner_ch
  import ide_common_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_LEN     = DEF_DEB_LEN,
  parameter int STRETCH     = DEF_STRETCH
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stretched
);

  localparam int DC_W = clog2(DEB_LEN + 1);
  localparam int SC_W = clog2(STRETCH + 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEB_LEN - 1);
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'((STRETCH > 0) ? STRETCH - 1 : 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DC_W-1:0]        r_dc;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [SC_W-1:0]        r_sc;
  logic                   r_stretched;

  logic                   w_s;
  logic [DC_W-1:0]        w_dc_next;
  logic                   w_level_next;
  logic                   w_rise_next;
  logic                   w_fall_next;
  logic [SC_W-1:0]        w_sc_next;
  logic                   w_stretched_next;

  assign w_s = r_sync[SYNC_STAGES-1];

  // State register process.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= '0;
      r_dc        <= '0;
      r_level     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_sc        <= '0;
      r_stretched <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], in};
      r_dc        <= w_dc_next;
      r_level     <= w_level_next;
      r_rise      <= w_rise_next;
      r_fall      <= w_fall_next;
      r_sc        <= w_sc_next;
      r_stretched <= w_stretched_next;
    end
  end

  // Debounce next state: dc==0 is stable, dc>0 is a pending disagreement.
  always_comb begin
    w_dc_next    = '0;
    w_level_next = r_level;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    if (w_s != r_level) begin
      if (r_dc == DC_LAST) begin
        w_level_next = w_s;
        w_rise_next  = w_s;
        w_fall_next  = ~w_s;
      end else begin
        w_dc_next = r_dc + 1'b1;
      end
    end
  end

  // Stretcher next state; STRETCH of 0 or 1 both collapse to a copy of rise.
  always_comb begin
    w_sc_next        = r_sc;
    w_stretched_next = r_stretched;
    if (w_rise_next) begin
      w_sc_next        = SC_LOAD;
      w_stretched_next = 1'b1;
    end else if (r_sc != '0) begin
      w_sc_next = r_sc - 1'b1;
    end else begin
      w_stretched_next = 1'b0;
    end
  end

  // Output process.
  always_comb begin
    level     = r_level;
    rise      = r_rise;
    fall      = r_fall;
    stretched = r_stretched;
  end

endmodule

// File: rtl/input_conditioner.sv
// N-channel input conditioner; the wrapper only slices buses onto channels.
module input_conditioner
  import ide_common_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_LEN     = DEF_DEB_LEN,
  parameter int STRETCH     = DEF_STRETCH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] stretched
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      input_conditioner_ch #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_LEN    (DEB_LEN),
        .STRETCH    (STRETCH)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .in       (in[gi]),
        .level    (level[gi]),
        .rise     (rise[gi]),
        .fall     (fall[gi]),
        .stretched(stretched[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Bench: three configurations share one stimulus; a window-based model checks every cycle.
module tb_input_conditioner;

  localparam int N    = 4;
  localparam int NC   = 3;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] in_v = '0;

  logic [N-1:0] d_level [NC];
  logic [N-1:0] d_rise  [NC];
  logic [N-1:0] d_fall  [NC];
  logic [N-1:0] d_str   [NC];

  int total = 0;
  int bad   = 0;
  int ec    = -1;

  logic [N-1:0] hist [$];
  logic [N-1:0] m_level [NC];
  logic [N-1:0] m_rise  [NC];
  logic [N-1:0] m_fall  [NC];
  logic [N-1:0] m_str   [NC];
  int           m_rem   [NC][N];
  int           cnt_rise [NC][N];
  int           cnt_fall [NC][N];
  int           cnt_str  [NC][N];

  always #5 clk = ~clk;

  input_conditioner #(.N(N)) u_def (
    .clk(clk), .rst(rst), .in(in_v),
    .level(d_level[0]), .rise(d_rise[0]), .fall(d_fall[0]), .stretched(d_str[0]));

  input_conditioner #(.N(N), .DEB_LEN(1), .STRETCH(8)) u_rt (
    .clk(clk), .rst(rst), .in(in_v),
    .level(d_level[1]), .rise(d_rise[1]), .fall(d_fall[1]), .stretched(d_str[1]));

  input_conditioner #(.N(N), .STRETCH(0)) u_s0 (
    .clk(clk), .rst(rst), .in(in_v),
    .level(d_level[2]), .rise(d_rise[2]), .fall(d_fall[2]), .stretched(d_str[2]));

  function automatic int cfg_deb(input int c);
    return (c == 1) ? 1 : 4;
  endfunction

  function automatic int cfg_str(input int c);
    return (c == 0) ? 4 : ((c == 1) ? 8 : 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, ec);
    end
  endtask

  // Synchronised value held after edge e: the input sampled SYNC-1 edges earlier.
  function automatic logic s_after(input int e, input int ch);
    int idx;
    logic [N-1:0] tmp;
    idx = e - SYNC + 1;
    if (idx < 0) return 1'b0;
    tmp = hist[idx];
    return tmp[ch];
  endfunction

  // Level flips once the DEB_LEN most recent synchronised samples all disagree with it.
  task automatic model_step();
    int t, deb, str;
    bit diff, r, f;
    t = hist.size() - 1;
    for (int c = 0; c < NC; c++) begin
      deb = cfg_deb(c);
      str = cfg_str(c);
      for (int i = 0; i < N; i++) begin
        r = 1'b0;
        f = 1'b0;
        if (t - deb >= -1) begin
          diff = 1'b1;
          for (int j = 1; j <= deb; j++)
            if (s_after(t - j, i) == m_level[c][i]) diff = 1'b0;
          if (diff) begin
            m_level[c][i] = ~m_level[c][i];
            if (m_level[c][i]) r = 1'b1;
            else f = 1'b1;
          end
        end
        m_rise[c][i] = r;
        m_fall[c][i] = f;
        if (r) m_rem[c][i] = str;
        else if (m_rem[c][i] > 0) m_rem[c][i] = m_rem[c][i] - 1;
        m_str[c][i] = (str == 0) ? r : (m_rem[c][i] > 0);
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("cfg%0d_level", c), 32'(d_level[c]), 32'(m_level[c]));
      chk($sformatf("cfg%0d_rise", c),  32'(d_rise[c]),  32'(m_rise[c]));
      chk($sformatf("cfg%0d_fall", c),  32'(d_fall[c]),  32'(m_fall[c]));
      chk($sformatf("cfg%0d_stretched", c), 32'(d_str[c]), 32'(m_str[c]));
      for (int i = 0; i < N; i++) begin
        cnt_rise[c][i] += int'(d_rise[c][i]);
        cnt_fall[c][i] += int'(d_fall[c][i]);
        cnt_str[c][i]  += int'(d_str[c][i]);
      end
    end
    chk("s0_stretched_eq_rise", 32'(d_str[2]), 32'(d_rise[2]));
  endtask

  // Model update on each edge, comparison 2 ns later.
  always begin
    @(posedge clk);
    if (!rst) begin
      ec = -1;
      hist.delete();
      for (int c = 0; c < NC; c++) begin
        m_level[c] = '0; m_rise[c] = '0; m_fall[c] = '0; m_str[c] = '0;
        for (int i = 0; i < N; i++) m_rem[c][i] = 0;
      end
    end else begin
      ec = ec + 1;
      hist.push_back(in_v);
      model_step();
    end
    #2;
    if (rst && ec >= 0) compare_all();
  end

  // Advance to 3 ns after edge n (edges counted from reset release).
  task automatic goto_edge(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (ec != n && guard < 500);
    if (ec != n) begin
      total++;
      bad++;
      $display("FAIL goto_edge: reached %0d required %0d", ec, n);
    end
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sr, sf, ss;
    repeat (3) @(posedge clk);
    #3;
    for (int c = 0; c < NC; c++)
      chk($sformatf("reset_outs_cfg%0d", c), 32'({d_level[c], d_rise[c], d_fall[c], d_str[c]}), 0);
    rst = 1'b1;
    $display("reset released");

    // Clean press on ch0, sampled at edge 10.
    goto_edge(9);
    in_v[0] = 1'b1;
    $display("press ch0");
    goto_edge(14);
    chk("press_level_e14", 32'(d_level[0][0]), 0);
    goto_edge(15);
    chk("press_level_e15", 32'(d_level[0][0]), 1);
    chk("press_rise_e15", 32'(d_rise[0][0]), 1);
    chk("press_str_e15", 32'(d_str[0][0]), 1);
    chk("s0_str_e15", 32'(d_str[2][0]), 1);
    goto_edge(16);
    chk("press_rise_e16", 32'(d_rise[0][0]), 0);
    chk("press_str_e16", 32'(d_str[0][0]), 1);
    chk("s0_str_e16", 32'(d_str[2][0]), 0);
    goto_edge(18);
    chk("press_str_e18", 32'(d_str[0][0]), 1);
    goto_edge(19);
    chk("press_str_e19", 32'(d_str[0][0]), 0);

    // Release after 20 stable cycles.
    goto_edge(29);
    sr = cnt_rise[0][0]; sf = cnt_fall[0][0];
    in_v[0] = 1'b0;
    $display("release ch0");
    goto_edge(35);
    chk("release_fall_e35", 32'(d_fall[0][0]), 1);
    goto_edge(45);
    chk("release_fall_count", cnt_fall[0][0] - sf, 1);
    chk("release_rise_count", cnt_rise[0][0] - sr, 0);

    // Three-cycle glitch on ch0.
    sr = cnt_rise[0][0]; ss = cnt_str[0][0];
    in_v[0] = 1'b1;
    $display("glitch ch0");
    goto_edge(48);
    in_v[0] = 1'b0;
    goto_edge(60);
    chk("glitch_rise_count", cnt_rise[0][0] - sr, 0);
    chk("glitch_str_count", cnt_str[0][0] - ss, 0);
    chk("glitch_level", 32'(d_level[0][0]), 0);

    // Retrigger on ch1 of the DEB_LEN=1 / STRETCH=8 instance.
    sr = cnt_rise[1][1]; ss = cnt_str[1][1];
    in_v[1] = 1'b1;
    $display("retrigger ch1");
    goto_edge(62);
    in_v[1] = 1'b0;
    goto_edge(63);
    chk("retrig_rise_e63", 32'(d_rise[1][1]), 1);
    goto_edge(64);
    in_v[1] = 1'b1;
    goto_edge(67);
    chk("retrig_rise_e67", 32'(d_rise[1][1]), 1);
    goto_edge(74);
    chk("retrig_str_e74", 32'(d_str[1][1]), 1);
    goto_edge(75);
    chk("retrig_str_e75", 32'(d_str[1][1]), 0);
    chk("retrig_str_count", cnt_str[1][1] - ss, 12);
    chk("retrig_rise_count", cnt_rise[1][1] - sr, 2);

    // Reset in the cycle after rise on ch2, input held high.
    in_v[2] = 1'b1;
    $display("press ch2 then reset");
    goto_edge(81);
    chk("prereset_rise_ch2", 32'(d_rise[0][2]), 1);
    rst = 1'b0;
    #1;
    for (int c = 0; c < NC; c++)
      chk($sformatf("async_reset_outs_cfg%0d", c), 32'({d_level[c], d_rise[c], d_fall[c], d_str[c]}), 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    goto_edge(4);
    chk("postreset_rise_e4", 32'(d_rise[0]), 0);
    goto_edge(5);
    chk("postreset_rise_e5", 32'(d_rise[0]), 32'h6);
    in_v = '0;

    // Offset overlapping presses: ch0, then ch3 with a ch1 glitch.
    goto_edge(20);
    in_v[0] = 1'b1;
    $display("independence ch0/ch3/ch1-glitch");
    goto_edge(21);
    in_v[3] = 1'b1;
    in_v[1] = 1'b1;
    goto_edge(23);
    in_v[1] = 1'b0;
    goto_edge(26);
    chk("indep_rise_e26", 32'(d_rise[0]), 32'h1);
    goto_edge(27);
    chk("indep_rise_e27", 32'(d_rise[0]), 32'h8);
    goto_edge(32);
    chk("indep_level_e32", 32'(d_level[0]), 32'h9);
    goto_edge(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
